// File: rtl/sm4_blk_seq.sv
// Block sequencer in front of the SM4 core: key expansion, per-block issue/collect,
// ECB/CBC chaining and a one-block output buffer with valid/ready backpressure.
module sm4_blk_seq #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cbc_i,
  input  logic             dec_i,
  input  logic [127:0]     key_i,
  input  logic [127:0]     iv_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  output logic             core_sm4_enable_o,
  output logic             core_encdec_enable_o,
  output logic             core_encdec_sel_o,
  output logic             core_valid_o,
  output logic             core_enable_key_exp_o,
  output logic             core_user_key_valid_o,
  output logic [127:0]     core_data_o,
  output logic [127:0]     core_user_key_o,
  input  logic [127:0]     core_result_i,
  input  logic             core_valid_i,
  input  logic             core_key_exp_ready_i
);

  localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYEXP, S_READY, S_ISSUE, S_WAIT, S_OUT, S_ERR
  } state_t;

  state_t         state;
  logic           cbc_q;
  logic           dec_q;
  logic           last_q;
  logic [127:0]   chain_q;
  logic [127:0]   saved_q;
  logic [TW-1:0]  timer_q;
  logic           timeout_hit;

  assign timeout_hit = (timer_q == TMAX);

  // NOTE: sequential state uses non-blocking assignments only; the defaults at the top of the
  // clocked branch make the pulse outputs self-clearing without any ordering hazards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state                 <= S_IDLE;
      cbc_q                 <= 1'b0;
      dec_q                 <= 1'b0;
      last_q                <= 1'b0;
      chain_q               <= '0;
      saved_q               <= '0;
      timer_q               <= '0;
      in_ready_o            <= 1'b0;
      out_valid_o           <= 1'b0;
      out_data_o            <= '0;
      out_last_o            <= 1'b0;
      busy_o                <= 1'b0;
      done_o                <= 1'b0;
      err_o                 <= 1'b0;
      blk_cnt_o             <= '0;
      core_sm4_enable_o     <= 1'b0;
      core_encdec_enable_o  <= 1'b0;
      core_encdec_sel_o     <= 1'b0;
      core_valid_o          <= 1'b0;
      core_enable_key_exp_o <= 1'b0;
      core_user_key_valid_o <= 1'b0;
      core_data_o           <= '0;
      core_user_key_o       <= '0;
    end else begin
      done_o                <= 1'b0;
      core_valid_o          <= 1'b0;
      core_user_key_valid_o <= 1'b0;

      if (abort_i) begin
        // Abort drops any in-flight or buffered block; the delivered count is left alone.
        state                 <= S_IDLE;
        in_ready_o            <= 1'b0;
        out_valid_o           <= 1'b0;
        out_last_o            <= 1'b0;
        busy_o                <= 1'b0;
        err_o                 <= 1'b0;
        core_sm4_enable_o     <= 1'b0;
        core_encdec_enable_o  <= 1'b0;
        core_encdec_sel_o     <= 1'b0;
        core_enable_key_exp_o <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_i) begin
              state                 <= S_KEYEXP;
              cbc_q                 <= cbc_i;
              dec_q                 <= dec_i;
              chain_q               <= iv_i;
              core_user_key_o       <= key_i;
              core_encdec_sel_o     <= dec_i;
              blk_cnt_o             <= '0;
              timer_q               <= '0;
              busy_o                <= 1'b1;
              core_sm4_enable_o     <= 1'b1;
              core_enable_key_exp_o <= 1'b1;
              core_user_key_valid_o <= 1'b1;
            end
          end

          S_KEYEXP: begin
            // The ready flag may still be high from the previous key during the first cycle.
            if (core_key_exp_ready_i && !core_user_key_valid_o) begin
              state                 <= S_READY;
              core_enable_key_exp_o <= 1'b0;
              core_encdec_enable_o  <= 1'b1;
              in_ready_o            <= 1'b1;
            end else if (timeout_hit) begin
              state                 <= S_ERR;
              err_o                 <= 1'b1;
              core_sm4_enable_o     <= 1'b0;
              core_encdec_sel_o     <= 1'b0;
              core_enable_key_exp_o <= 1'b0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end

          S_READY: begin
            if (in_valid_i) begin
              state        <= S_ISSUE;
              in_ready_o   <= 1'b0;
              core_data_o  <= (cbc_q && !dec_q) ? (in_data_i ^ chain_q) : in_data_i;
              saved_q      <= in_data_i;
              last_q       <= in_last_i;
              core_valid_o <= 1'b1;
            end
          end

          S_ISSUE: begin
            state   <= S_WAIT;
            timer_q <= '0;
          end

          S_WAIT: begin
            if (core_valid_i) begin
              state       <= S_OUT;
              out_data_o  <= (cbc_q && dec_q) ? (core_result_i ^ chain_q) : core_result_i;
              out_last_o  <= last_q;
              out_valid_o <= 1'b1;
              if (cbc_q) chain_q <= dec_q ? saved_q : core_result_i;
            end else if (timeout_hit) begin
              state                <= S_ERR;
              err_o                <= 1'b1;
              core_sm4_enable_o    <= 1'b0;
              core_encdec_enable_o <= 1'b0;
              core_encdec_sel_o    <= 1'b0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end

          S_OUT: begin
            if (out_ready_i) begin
              out_valid_o <= 1'b0;
              out_last_o  <= 1'b0;
              blk_cnt_o   <= blk_cnt_o + CNT_W'(1);
              if (last_q) begin
                state                <= S_IDLE;
                done_o               <= 1'b1;
                busy_o               <= 1'b0;
                core_sm4_enable_o    <= 1'b0;
                core_encdec_enable_o <= 1'b0;
              end else begin
                state      <= S_READY;
                in_ready_o <= 1'b1;
              end
            end
          end

          S_ERR: begin
            state <= S_ERR;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
